ram_clear: RTL
==============

Name: ram_clear

Overview:
- Sits directly upstream of the 128 KiB scrambled SPRAM block, between the CPU memory port and the RAM port.
- After reset, and on request, it sweeps every RAM word and writes a fill value, so no stale data survives an application switch.
- While no sweep is running, CPU accesses pass through to the RAM unchanged.
- During a sweep, CPU accesses are stalled: cpu_ready is held low.

Parameters:
- WORDS, 32768: number of 32-bit words swept. Sweep addresses run 0..WORDS-1. Benches use small values.
- CLEAR_ON_RESET, 1: if 1, a sweep starts automatically when reset is released. If 0, the block leaves reset in PASS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- clear_req  in  1  single-cycle request to start a sweep.
- fill_data  in  32  value written to each word; sampled every sweep cycle (constant or TRNG output).
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a sweep completes.
- cpu_cs  in  1  CPU request; held asserted until cpu_ready.
- cpu_we  in  4  CPU byte write enables.
- cpu_address  in  16  CPU word address.
- cpu_write_data  in  32  CPU write data.
- cpu_read_data  out  32  read data returned to the CPU.
- cpu_ready  out  1  CPU access complete.
- ram_cs  out  1  RAM chip select.
- ram_we  out  4  RAM byte write enables.
- ram_address  out  16  RAM word address.
- ram_write_data  out  32  RAM write data.
- ram_read_data  in  32  RAM read data (already descrambled by the RAM).
- ram_ready  in  1  RAM ready; the RAM asserts it one cycle after ram_cs.

Behaviour:
- States:
  - CLEAR: sweep in progress.
  - PASS: CPU pass-through.
- Registers:
  - cnt: 16-bit sweep counter.
  - pend: pending clear request.
  - prev_pass: 1 if the previous cycle was PASS with cpu_cs=1.
- Reset (reset_n=0 at a clk edge):
  - State becomes CLEAR if CLEAR_ON_RESET, else PASS.
  - cnt=0, pend=0, prev_pass=0, done=0.
  - A reset during a sweep aborts it; the next sweep restarts from address 0.
- CLEAR, each cycle:
  - Drives ram_cs=1, ram_we=4'hF, ram_address=cnt, ram_write_data=fill_data.
  - cnt increments by 1. There is no backpressure; the RAM accepts one write per cycle.
  - When the cycle writing cnt=WORDS-1 completes: state becomes PASS, cnt=0, done=1 for exactly the next cycle.
  - A sweep therefore takes exactly WORDS cycles.
- busy equals (state==CLEAR), taken combinationally from the state register.
- CPU side during CLEAR:
  - cpu_ready=0 and cpu_read_data=0.
  - A CPU request is stalled, not dropped; it completes after the sweep ends.
- PASS:
  - ram_cs/ram_we/ram_address/ram_write_data equal the cpu_* inputs combinationally.
  - cpu_read_data=ram_read_data.
  - cpu_ready=ram_ready & prev_pass. This masks the stale ram_ready produced by the final sweep write.
- Read latency in PASS: 1 cycle, identical to the RAM alone.
- clear_req handling:
  - In PASS, clear_req sets pend.
  - pend is taken (state goes to CLEAR, pend cleared) on the first PASS cycle with cpu_cs=0 and no completion pending (prev_pass=0). An in-flight CPU access is never cut.
  - clear_req in the same cycle as a grant opportunity is granted immediately.
  - clear_req while in CLEAR is ignored; it does not restart the sweep.
- Wrap and width:
  - cnt compares against WORDS-1 and never wraps past it.
  - Addresses at or above WORDS are never written by the sweep.
- done:
  - Is never asserted during reset.
  - Is never asserted for an aborted sweep.

Decomposition:
- Shared package holds:
  - RAM_WORDS=32768.
  - The state encoding constants CTRL_CLEAR and CTRL_PASS.
  - The width constants RAM_ADDR_W=16 and RAM_DATA_W=32, also used by the RAM block.
- No sub-module. The FSM, counter and mux fit in a single module.

Test Plan:
- Reset release with WORDS=16, CLEAR_ON_RESET=1, fill_data=32'hDEADBEEF:
  - busy is high for 16 cycles with ram_we=4'hF and ram_address 0..15.
  - done pulses once, then busy=0.
  - A RAM model holds DEADBEEF at all 16 words.
- CPU read of address 5 issued mid-sweep:
  - cpu_ready stays 0 during the sweep.
  - After done, cpu_ready=1 exactly 1 cycle after the pass-through cs, with cpu_read_data=32'hDEADBEEF.
- In PASS: CPU writes 32'h12345678 with we=4'b0011 to address 3, then reads address 3:
  - Readback is {16'hDEAD,16'h5678}.
  - No ready is seen on the cycle following the write's completion except for its own access.
- clear_req asserted while cpu_cs=1 on a pending read:
  - The read completes with correct data.
  - The sweep starts on the first cycle with cpu_cs=0.
  - done follows 16 cycles later.
- clear_req pulsed at sweep cycle 8:
  - The sweep length stays 16 cycles and done pulses once.
  - reset_n=0 at sweep cycle 8 restarts the sweep from address 0 after release, with no done before completion.
- CLEAR_ON_RESET=0:
  - After reset, busy=0 and CPU pass-through works immediately.
  - cpu_ready is not asserted on the first cycle after reset.

Source files
------------

// File: rtl/ram_clear_pkg.sv
// ram_clear_pkg: constants and types shared by the RAM clear controller and
// the SPRAM block it fronts.
// Contents: RAM geometry (words, address/data widths) and the controller
// state encoding.
package ram_clear_pkg;

  localparam int RAM_WORDS  = 32768;
  localparam int RAM_ADDR_W = 16;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_WE_W   = RAM_DATA_W / 8;

  typedef enum logic {
    CTRL_CLEAR = 1'b0,
    CTRL_PASS  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ram_clear_if.sv
// ram_clear_if: word-addressed memory port with per-byte write enables.
// Ports: cs/we/address/write_data flow from requester to memory,
// read_data/ready flow back; ready completes the access held on cs.
interface ram_clear_if;
  import ram_clear_pkg::*;

  logic                  cs;
  logic [RAM_WE_W-1:0]   we;
  logic [RAM_ADDR_W-1:0] address;
  logic [RAM_DATA_W-1:0] write_data;
  logic [RAM_DATA_W-1:0] read_data;
  logic                  ready;

  // Requester side (CPU, or this controller towards the RAM).
  modport master (
    output cs, we, address, write_data,
    input  read_data, ready
  );

  // Memory side (the RAM, or this controller towards the CPU).
  modport slave (
    input  cs, we, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/ram_clear.sv
// ram_clear: sits in front of the SPRAM; after reset and on request it writes
// fill_data_i to every word, otherwise CPU accesses pass straight through.
// Ports: clk, reset_n (synchronous, active-low); clear_req_i one-cycle sweep
// request; fill_data_i sampled each sweep cycle; busy_o high while sweeping;
// done_o one-cycle completion pulse; cpu_io CPU-facing port; ram_io RAM port.
module ram_clear
  import ram_clear_pkg::*;
#(
  parameter int WORDS          = RAM_WORDS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req_i,
  input  logic [RAM_DATA_W-1:0] fill_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  ram_clear_if.slave            cpu_io,
  ram_clear_if.master           ram_io
);

  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(WORDS - 1);

  ctrl_state_e           state_q, state_d;
  logic [RAM_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  prev_pass_q, prev_pass_d;
  logic                  done_q, done_d;
  logic                  grant;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= CLEAR_ON_RESET ? CTRL_CLEAR : CTRL_PASS;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      prev_pass_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      prev_pass_q <= prev_pass_d;
      done_q      <= done_d;
    end
  end

  // A sweep may only start when the CPU is idle and no RAM completion for a
  // previous pass-through access is still on its way back.
  assign grant = (pend_q | clear_req_i) & ~cpu_io.cs & ~prev_pass_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    prev_pass_d = 1'b0;
    done_d      = 1'b0;

    ram_io.cs         = cpu_io.cs;
    ram_io.we         = cpu_io.we;
    ram_io.address    = cpu_io.address;
    ram_io.write_data = cpu_io.write_data;

    cpu_io.read_data  = ram_io.read_data;
    // The RAM's ready after the last sweep write is not a CPU completion;
    // only pass a ready through when the previous cycle carried a CPU cs.
    cpu_io.ready      = ram_io.ready & prev_pass_q;

    case (state_q)
      CTRL_CLEAR: begin
        ram_io.cs         = 1'b1;
        ram_io.we         = '1;
        ram_io.address    = cnt_q;
        ram_io.write_data = fill_data_i;
        cpu_io.read_data  = '0;
        cpu_io.ready      = 1'b0;
        // Requests during a sweep are dropped rather than queued.
        pend_d            = 1'b0;
        if (cnt_q == LAST_ADDR) begin
          state_d = CTRL_PASS;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + RAM_ADDR_W'(1);
        end
      end
      CTRL_PASS: begin
        prev_pass_d = cpu_io.cs;
        if (grant) begin
          state_d = CTRL_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          pend_d = pend_q | clear_req_i;
        end
      end
      default: begin
        state_d = CTRL_PASS;
      end
    endcase
  end

  assign busy_o = (state_q == CTRL_CLEAR);
  assign done_o = done_q;

endmodule
